// File: rtl/module_1.sv
// -----------------------------------------------------------------------------
// module_1 : second radix-2 DIF butterfly stage, 512-point FFT, LANES lanes/beat
//
// A frame is 32 beats, split into two groups of 16. In each group the first
// 8 beats (half A) are stored. Each of the next 8 beats (half B) is paired
// with the stored beat that is 8 beats older. The B beat emits the sum at
// once and writes the difference back into that buffer slot. After the last
// B beat of a group, the 8 stored differences are drained on consecutive
// cycles. Every result carries one bit of growth. No twiddles are applied.
//
// Ports
//   clk          rising-edge clock
//   rstn         synchronous active-low reset
//   in_re/in_im  [0:LANES-1] signed IN_W-bit input lanes
//   din_valid    input beat qualifier
//   out_re/out_im[0:LANES-1] signed IN_W+1-bit results, registered
//   dout_valid   output beat qualifier
//   dout_diff    1 = difference (drain) beat, 0 = sum beat
//   dout_last    final output beat of a 512-sample frame
// -----------------------------------------------------------------------------
module module_1 #(
    parameter int IN_W  = 11,
    parameter int LANES = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic signed [IN_W-1:0] in_re [0:LANES-1],
    input  logic signed [IN_W-1:0] in_im [0:LANES-1],
    input  logic                   din_valid,
    output logic signed [IN_W:0]   out_re [0:LANES-1],
    output logic signed [IN_W:0]   out_im [0:LANES-1],
    output logic                   dout_valid,
    output logic                   dout_diff,
    output logic                   dout_last
);
    localparam int OW = IN_W + 1;

    logic [4:0] bcnt_reg, bcnt_next;
    logic       pend_reg, pend_next;
    logic [2:0] dptr_reg, dptr_next;
    logic       last_grp_reg, last_grp_next;

    logic [2:0] slot;
    logic       a_beat;
    logic       b_beat;
    logic [2:0] rd_addr;

    assign slot   = bcnt_reg[2:0];
    assign a_beat = din_valid & ~bcnt_reg[3];
    assign b_beat = din_valid &  bcnt_reg[3];
    // A B beat never overlaps a drain, so one shared read address is enough:
    // the drain pointer while draining, otherwise the current slot.
    assign rd_addr = pend_reg ? dptr_reg : slot;

    always_comb begin
        bcnt_next     = bcnt_reg;
        pend_next     = pend_reg;
        dptr_next     = dptr_reg;
        last_grp_next = last_grp_reg;
        if (din_valid) begin
            bcnt_next = bcnt_reg + 5'd1;
        end
        if (b_beat && (slot == 3'd7)) begin
            pend_next     = 1'b1;
            dptr_next     = 3'd0;
            last_grp_next = bcnt_reg[4];
        end else if (pend_reg) begin
            dptr_next = dptr_reg + 3'd1;
            if (dptr_reg == 3'd7) begin
                pend_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bcnt_reg     <= '0;
            pend_reg     <= 1'b0;
            dptr_reg     <= '0;
            last_grp_reg <= 1'b0;
            dout_valid   <= 1'b0;
            dout_diff    <= 1'b0;
            dout_last    <= 1'b0;
        end else begin
            bcnt_reg     <= bcnt_next;
            pend_reg     <= pend_next;
            dptr_reg     <= dptr_next;
            last_grp_reg <= last_grp_next;
            dout_valid   <= b_beat | pend_reg;
            dout_diff    <= pend_reg & ~b_beat;
            dout_last    <= pend_reg & ~b_beat & (dptr_reg == 3'd7) & last_grp_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [OW-1:0] mem_re [0:7];
            logic signed [OW-1:0] mem_im [0:7];
            logic signed [OW-1:0] x_re, x_im;
            logic signed [OW-1:0] rd_re, rd_im;
            logic signed [OW-1:0] res_re_reg, res_im_reg;

            assign x_re  = OW'(in_re[gi]);
            assign x_im  = OW'(in_im[gi]);
            assign rd_re = mem_re[rd_addr];
            assign rd_im = mem_im[rd_addr];

            // Buffer contents are don't-care after reset, so no reset here.
            // On an A beat the slot takes the new sample; on a B beat it takes
            // the difference. Reads above see the old content of the slot.
            always_ff @(posedge clk) begin
                if (rstn && din_valid) begin
                    mem_re[slot] <= a_beat ? x_re : (rd_re - x_re);
                    mem_im[slot] <= a_beat ? x_im : (rd_im - x_im);
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    res_re_reg <= '0;
                    res_im_reg <= '0;
                end else if (b_beat) begin
                    res_re_reg <= rd_re + x_re;
                    res_im_reg <= rd_im + x_im;
                end else if (pend_reg) begin
                    res_re_reg <= rd_re;
                    res_im_reg <= rd_im;
                end
            end

            assign out_re[gi] = res_re_reg;
            assign out_im[gi] = res_im_reg;
        end
    endgenerate

endmodule

// File: tb/tb_module_1.sv
// -----------------------------------------------------------------------------
// tb_module_1 : self-checking bench for module_1.
// Inputs are driven on the falling edge. Outputs are checked on the next
// falling edge against a frame-level model. The model stores the A half of
// each group and pairs it with the B half. It forms sums when each B beat
// arrives and queues the 8 differences for the cycles after the group ends.
// -----------------------------------------------------------------------------
module tb_module_1;
    localparam int IN_W  = 11;
    localparam int LANES = 16;
    localparam int OW    = IN_W + 1;

    logic clk;
    logic rstn;
    logic din_valid;
    logic signed [IN_W-1:0] in_re [0:LANES-1];
    logic signed [IN_W-1:0] in_im [0:LANES-1];
    logic signed [OW-1:0]   out_re [0:LANES-1];
    logic signed [OW-1:0]   out_im [0:LANES-1];
    logic dout_valid, dout_diff, dout_last;

    module_1 #(.IN_W(IN_W), .LANES(LANES)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_re     (in_re),
        .in_im     (in_im),
        .din_valid (din_valid),
        .out_re    (out_re),
        .out_im    (out_im),
        .dout_valid(dout_valid),
        .dout_diff (dout_diff),
        .dout_last (dout_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a_re, a_im, b_re, b_im;
        int s_re, s_im, d_re, d_im;
    } vec_t;
    vec_t tab [5];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 0;
    bit tab_on = 0;
    int tab_idx = 0;
    int run_len = 0, max_run = 0, last_cnt = 0;

    int drv_re [LANES];
    int drv_im [LANES];

    // frame-level reference model state
    int mcnt;
    int hre [8][LANES];
    int him [8][LANES];
    int dre [8][LANES];
    int dim [8][LANES];
    int dleft = 0, didx = 0;
    bit dlast = 0;
    int exp_re [LANES];
    int exp_im [LANES];
    bit exp_v = 0, exp_d = 0, exp_l = 0, exp_zero = 0;

    function automatic void model(input logic v, input logic rn);
        bit bb;
        int pos, p, g;
        bb = 0;
        exp_v = 0; exp_d = 0; exp_l = 0;
        if (!rn) begin
            mcnt = 0; dleft = 0; didx = 0; exp_zero = 1;
            for (int l = 0; l < LANES; l++) begin exp_re[l] = 0; exp_im[l] = 0; end
        end else begin
            if (v) begin
                pos = mcnt % 16;
                g   = mcnt / 16;
                if (pos < 8) begin
                    for (int l = 0; l < LANES; l++) begin
                        hre[pos][l] = drv_re[l]; him[pos][l] = drv_im[l];
                    end
                end else begin
                    p = pos - 8; bb = 1; exp_v = 1;
                    for (int l = 0; l < LANES; l++) begin
                        exp_re[l] = hre[p][l] + drv_re[l];
                        exp_im[l] = him[p][l] + drv_im[l];
                        dre[p][l] = hre[p][l] - drv_re[l];
                        dim[p][l] = him[p][l] - drv_im[l];
                    end
                    if (p == 7) begin dleft = 8; didx = 0; dlast = (g == 1); end
                end
                mcnt = (mcnt + 1) % 32;
            end
            if (!bb && dleft > 0) begin
                exp_v = 1; exp_d = 1;
                for (int l = 0; l < LANES; l++) begin
                    exp_re[l] = dre[didx][l]; exp_im[l] = dim[didx][l];
                end
                didx++; dleft--;
                exp_l = dlast && (dleft == 0);
            end
            if (exp_v) exp_zero = 0;
        end
    endfunction

    task automatic check_outputs();
        int bad_l;
        int want_re, want_im;
        logic signed [OW-1:0] e_re, e_im;
        if (chk_en) begin
            n_cmp++;
            if ({dout_valid, dout_diff, dout_last} !== {exp_v, exp_d, exp_l}) begin
                n_bad++;
                $display("FAIL ctrl cyc=%0d got v/d/l=%b%b%b want %b%b%b",
                         cyc, dout_valid, dout_diff, dout_last, exp_v, exp_d, exp_l);
            end
            if (exp_v || exp_zero) begin
                bad_l = -1;
                for (int l = LANES - 1; l >= 0; l--) begin
                    e_re = OW'(exp_re[l]); e_im = OW'(exp_im[l]);
                    if (out_re[l] !== e_re || out_im[l] !== e_im) bad_l = l;
                end
                n_cmp++;
                if (bad_l >= 0) begin
                    n_bad++;
                    $display("FAIL data cyc=%0d lane=%0d got %0d/%0d want %0d/%0d", cyc, bad_l,
                             out_re[bad_l], out_im[bad_l], exp_re[bad_l], exp_im[bad_l]);
                end
            end
            if (tab_on && exp_v) begin
                want_re = exp_d ? tab[tab_idx].d_re : tab[tab_idx].s_re;
                want_im = exp_d ? tab[tab_idx].d_im : tab[tab_idx].s_im;
                e_re = OW'(want_re); e_im = OW'(want_im);
                n_cmp++;
                if (out_re[LANES-1] !== e_re || out_im[LANES-1] !== e_im || out_re[0] !== e_re) begin
                    n_bad++;
                    $display("FAIL vec%0d cyc=%0d diff=%b got %0d/%0d want %0d/%0d", tab_idx, cyc,
                             exp_d, out_re[LANES-1], out_im[LANES-1], want_re, want_im);
                end
            end
            if (dout_valid === 1'b1) run_len++; else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (dout_last === 1'b1) last_cnt++;
        end
    endtask

    task automatic step(input logic v, input logic rn);
        @(negedge clk);
        check_outputs();
        rstn = rn;
        din_valid = v;
        for (int l = 0; l < LANES; l++) begin
            in_re[l] = IN_W'(drv_re[l]);
            in_im[l] = IN_W'(drv_im[l]);
        end
        model(v, rn);
        chk_en = 1;
        cyc++;
    endtask

    task automatic set_junk();
        for (int l = 0; l < LANES; l++) begin
            drv_re[l] = int'($urandom_range(0, 2047)) - 1024;
            drv_im[l] = int'($urandom_range(0, 2047)) - 1024;
        end
    endtask

    // kind 0: table record, 1: ramp, 2: random
    task automatic set_beat(input int kind, input int b, input int rec);
        for (int l = 0; l < LANES; l++) begin
            if (kind == 0) begin
                drv_re[l] = ((b % 16) < 8) ? tab[rec].a_re : tab[rec].b_re;
                drv_im[l] = ((b % 16) < 8) ? tab[rec].a_im : tab[rec].b_im;
            end else if (kind == 1) begin
                drv_re[l] = b; drv_im[l] = 0;
            end else begin
                drv_re[l] = int'($urandom_range(0, 2047)) - 1024;
                drv_im[l] = int'($urandom_range(0, 2047)) - 1024;
            end
        end
    endtask

    // gap_mode 0: contiguous, 1: 3-cycle gaps before beats 4 and 12, 2: random gaps
    task automatic frame(input int kind, input int rec, input int gap_mode, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if (gap_mode == 1 && (b == 4 || b == 12)) begin
                repeat (3) begin set_junk(); step(1'b0, 1'b1); end
            end
            if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin set_junk(); step(1'b0, 1'b1); end
            end
            set_beat(kind, b, rec);
            step(1'b1, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin set_junk(); step(1'b0, 1'b1); end
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        tab[0] = '{100, -50, 100, -50, 200, -100, 0, 0};
        tab[1] = '{-1024, -1024, -1024, -1024, -2048, -2048, 0, 0};
        tab[2] = '{1023, 1023, -1024, -1024, -1, -1, 2047, 2047};
        tab[3] = '{-1024, 0, 1023, 5, -1, 5, -2047, -5};
        tab[4] = '{511, -300, -511, 300, 0, 0, 1022, -600};

        rstn = 1'b0;
        din_valid = 1'b0;
        set_junk();
        for (int l = 0; l < LANES; l++) begin in_re[l] = '0; in_im[l] = '0; end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        idle(2);

        // constant-frame vectors, one isolated frame per record
        for (int r = 0; r < 5; r++) begin
            tab_on = 1; tab_idx = r;
            max_run = 0; last_cnt = 0;
            frame(0, r, 0, 32);
            idle(12);
            tab_on = 0;
            expect_int("single_frame_run", max_run, 32);
            expect_int("single_frame_last", last_cnt, 1);
            $display("vector %0d: A=%0d/%0d B=%0d/%0d done", r,
                     tab[r].a_re, tab[r].a_im, tab[r].b_re, tab[r].b_im);
        end

        // ramp frame
        frame(1, 0, 0, 32);
        idle(12);
        $display("ramp frame done");

        // 3-cycle gaps before beats 4 and 12
        frame(2, 0, 1, 32);
        idle(12);
        $display("gap frame done");

        // two frames back to back
        max_run = 0; last_cnt = 0;
        frame(2, 0, 0, 32);
        frame(2, 0, 0, 32);
        idle(12);
        expect_int("b2b_run", max_run, 64);
        expect_int("b2b_last", last_cnt, 2);
        $display("back-to-back frames done");

        // reset at beat 12 with din_valid high, then a clean constant frame
        frame(2, 0, 0, 12);
        set_beat(2, 12, 0);
        step(1'b1, 1'b0);
        max_run = 0; last_cnt = 0;
        tab_on = 1; tab_idx = 0;
        frame(0, 0, 0, 32);
        idle(12);
        tab_on = 0;
        expect_int("post_reset_run", max_run, 32);
        expect_int("post_reset_last", last_cnt, 1);
        $display("mid-frame reset done");

        // random frames, contiguous and with random gaps
        for (int f = 0; f < 8; f++) begin
            frame(2, 0, (f < 4) ? 0 : 2, 32);
            $display("random frame %0d done", f);
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
